pps_filt_seq: RTL

PPS_FILT_SEQ -- requirements
Module: pps_filt_seq

---
 rtl/pps_filt_pkg.sv | 51 +++++
 rtl/pps_sat_round.sv | 32 +++
 rtl/pps_filt_seq.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/pps_filt_pkg.sv
// Shared definitions for the serial pulse-shaping FIR (pps_filt_seq).
// Holds the FSM state encoding, the default tap table and the
// rounding/saturation width helpers used by pps_sat_round.
package pps_filt_pkg;

   localparam int NTAPS_DEF    = 21;
   localparam int DW_DEF       = 18;
   localparam int CW_DEF       = 18;

   // Default taps are 1s17 words stored from the centre tap outward, so any
   // odd filter length up to 2*COEF_TAB_LEN-1 takes the innermost entries.
   localparam int COEF_TAB_W   = 18;
   localparam int COEF_TAB_LEN = 11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MAC   = 2'd1,
      ST_ROUND = 2'd2
   } pps_state_t;

   localparam logic [COEF_TAB_W-1:0] COEF_TAB [COEF_TAB_LEN] = '{
      18'h1FFFF,   // centre, ~1.0
      18'h10000,   //  0.5
      18'h04000,   //  0.125
      18'h3E800,   // -0.046875
      18'h3F000,   // -0.03125
      18'h00400,
      18'h00800,
      18'h3FE00,
      18'h3FF00,
      18'h00080,
      18'h00040
   };

   // Default tap at distance idx from the centre; zero beyond the table.
   function automatic logic [COEF_TAB_W-1:0] coef_tab(input int idx);
      if (idx < 0 || idx >= COEF_TAB_LEN) return '0;
      return COEF_TAB[idx];
   endfunction

   // Coefficients are 1s(CW-1): the product carries CW-1 fraction bits to drop.
   function automatic int rnd_shift(input int cw);
      return cw - 1;
   endfunction

   // Half an output LSB, for round-half-up before the shift.
   function automatic int rnd_bias_pos(input int cw);
      return cw - 2;
   endfunction

endpackage

// File: rtl/pps_sat_round.sv
// Accumulator to DW-bit output: round half up, drop the coefficient
// fraction bits, then clamp to the signed DW-bit range.
module pps_sat_round
   import pps_filt_pkg::*;
#(
   parameter int AW = 40,
   parameter int DW = 18,
   parameter int CW = 18
)(
   input  logic signed [AW-1:0] acc,
   output logic signed [DW-1:0] y_sat
);

   localparam int SW = AW + 1;
   localparam int SH = rnd_shift(CW);
   localparam logic signed [SW-1:0] BIAS  = SW'(1) <<< rnd_bias_pos(CW);
   localparam logic signed [SW-1:0] Y_MAX = (SW'(1) <<< (DW - 1)) - SW'(1);
   localparam logic signed [SW-1:0] Y_MIN = ~Y_MAX;

   logic signed [SW-1:0] biased;
   logic signed [SW-1:0] shifted;

   // Extra headroom bit keeps the bias add from wrapping at full scale.
   always_comb begin
      biased  = SW'(acc) + BIAS;
      shifted = biased >>> SH;
      if (shifted > Y_MAX)      y_sat = Y_MAX[DW-1:0];
      else if (shifted < Y_MIN) y_sat = Y_MIN[DW-1:0];
      else                      y_sat = shifted[DW-1:0];
   end

endmodule

// File: rtl/pps_filt_seq.sv
// Serial symmetric pulse-shaping FIR: one output per sample strobe, using a
// single multiplier over M=(NTAPS+1)/2 folded taps.
// Build option PPS_COEF_LOAD_EN: coefficients live in M writable registers
// behind coef_wr_en/coef_addr/coef_data/coef_ready; without it they are
// constants taken from pps_filt_pkg.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | waiting for sam_clk_en; coefficient writes allowed
//   ST_MAC   | M cycles, one folded tap multiplied per cycle
//   ST_ROUND | last product folded into acc; y registers next cycle
//
// Products are registered before accumulation, so y lands M+2 cycles
// after the accepted strobe.
module pps_filt_seq
   import pps_filt_pkg::*;
#(
   parameter int NTAPS = NTAPS_DEF,
   parameter int DW    = DW_DEF,
   parameter int CW    = CW_DEF
)(
   input  logic                              sys_clk,
   input  logic                              reset_n,
   input  logic                              sam_clk_en,
   input  logic signed [DW-1:0]              x_in,
`ifdef PPS_COEF_LOAD_EN
   input  logic                              coef_wr_en,
   input  logic [$clog2((NTAPS+1)/2)-1:0]    coef_addr,
   input  logic signed [CW-1:0]              coef_data,
   output logic                              coef_ready,
`endif
   output logic signed [DW-1:0]              y,
   output logic                              y_valid,
   output logic                              busy,
   output logic                              overrun
);

   localparam int M   = (NTAPS + 1) / 2;
   localparam int MW  = $clog2(M);
   localparam int PW  = DW + 1;
   localparam int MPW = DW + CW + 1;
   localparam int AW  = MPW + $clog2(M);

   pps_state_t               state;
   logic [MW-1:0]            cnt;
   logic signed [DW-1:0]     d [NTAPS];
   logic signed [AW-1:0]     acc;
   logic signed [MPW-1:0]    prod;
   logic                     rnd_pend;

   logic signed [CW-1:0]     coef [M];
   logic [MW-1:0]            tap;
   logic signed [PW-1:0]     pre;
   logic signed [CW-1:0]     c_sel;
   logic signed [MPW-1:0]    mul;
   logic signed [DW-1:0]     y_rnd;

   // Table words are 1s17; rescale to the CW-bit coefficient format.
   function automatic logic signed [CW-1:0] coef_init(input int k);
      logic [COEF_TAB_W-1:0]    t;
      logic [CW+COEF_TAB_W-1:0] ext;
      t   = coef_tab(M - 1 - k);
      ext = {t, {CW{1'b0}}};
      return ext[CW+COEF_TAB_W-1 -: CW];
   endfunction

`ifdef PPS_COEF_LOAD_EN
   logic coef_wr_ok;

   assign coef_ready = (state == ST_IDLE);
   assign coef_wr_ok = coef_wr_en && coef_ready && (32'(coef_addr) < M);

   // Coefficient registers; a write alongside a strobe is seen by that sample.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < M; i++) coef[i] <= coef_init(i);
      end else if (coef_wr_ok) begin
         coef[coef_addr] <= coef_data;
      end
   end
`else
   for (genvar g = 0; g < M; g++) begin : g_coef
      assign coef[g] = coef_init(g);
   end
`endif

   assign busy = (state != ST_IDLE);

   // Folded pre-add and coefficient select for the tap the down-counter points at.
   always_comb begin
      tap   = MW'(M - 1) - cnt;
      pre   = '0;
      c_sel = '0;
      for (int i = 0; i < M; i++) begin
         if (tap == MW'(i)) begin
            c_sel = coef[i];
            if (i == M - 1)
               pre = {d[i][DW-1], d[i]};
            else
               pre = {d[i][DW-1], d[i]} + {d[NTAPS-1-i][DW-1], d[NTAPS-1-i]};
         end
      end
   end

   assign mul = MPW'(pre) * MPW'(c_sel);

   pps_sat_round #(
      .AW (AW),
      .DW (DW),
      .CW (CW)
   ) u_sat_round (
      .acc   (acc),
      .y_sat (y_rnd)
   );

   // Sequencer: delay-line shift, MAC pipeline, output register and overrun flag.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         acc      <= '0;
         prod     <= '0;
         rnd_pend <= 1'b0;
         y        <= '0;
         y_valid  <= 1'b0;
         overrun  <= 1'b0;
         for (int i = 0; i < NTAPS; i++) d[i] <= '0;
      end else begin
         y_valid  <= 1'b0;
         rnd_pend <= 1'b0;
         if (rnd_pend) begin
            y       <= y_rnd;
            y_valid <= 1'b1;
         end
         if (sam_clk_en && state != ST_IDLE) overrun <= 1'b1;

         case (state)
            ST_IDLE: begin
               if (sam_clk_en) begin
                  d[0] <= x_in;
                  for (int i = 1; i < NTAPS; i++) d[i] <= d[i-1];
                  acc   <= '0;
                  prod  <= '0;
                  cnt   <= MW'(M - 1);
                  state <= ST_MAC;
               end
            end
            ST_MAC: begin
               prod <= mul;
               acc  <= acc + AW'(prod);
               if (cnt == '0) state <= ST_ROUND;
               else           cnt   <= cnt - 1'b1;
            end
            ST_ROUND: begin
               acc      <= acc + AW'(prod);
               rnd_pend <= 1'b1;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
